mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single physical memory port between the instruction fetch unit (IFU) and the load/store unit (LSU).
- The memory port is a combinational DPI-backed pmem port (ren/wen/raddr/rdata/waddr/wdata/mask).
- The block arbitrates requests, latches the winning request and sequences exactly one memory strobe per transaction after a configurable latency.
- It returns a one-cycle response pulse to the owning requester.
- It sits between IFU/LSU and the memory wrapper in the npc core.

Parameters:
- LATENCY, 1, cycles from request acceptance to the memory strobe (legal range 1..15).
- ADDR_W, 64, address width.
- DATA_W, 64, data width; the mask is DATA_W/8 bits wide.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ifu_req_valid  in  1  IFU read request.
- ifu_req_ready  out  1  IFU request accepted this cycle when high together with valid.
- ifu_addr  in  ADDR_W  IFU read address.
- ifu_resp_valid  out  1  one-cycle pulse; ifu_rdata is valid in that cycle.
- ifu_rdata  out  DATA_W  fetched data.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted this cycle when high together with valid.
- lsu_wen  in  1  1 = write, 0 = read.
- lsu_addr  in  ADDR_W  LSU address.
- lsu_wdata  in  DATA_W  store data.
- lsu_mask  in  DATA_W/8  store byte mask.
- lsu_resp_valid  out  1  one-cycle pulse; load data valid, or store acknowledged.
- lsu_rdata  out  DATA_W  load data; 0 for stores.
- mem_ren  out  1  memory read strobe.
- mem_wen  out  1  memory write strobe.
- mem_raddr  out  ADDR_W  read address; 0 when mem_ren is low.
- mem_rdata  in  DATA_W  read data, combinational from mem_raddr/mem_ren.
- mem_waddr  out  ADDR_W  write address; 0 when mem_wen is low.
- mem_wdata  out  DATA_W  write data; 0 when mem_wen is low.
- mem_mask  out  DATA_W/8  write mask; 0 when mem_wen is low.

Behaviour:
- States:
  - IDLE.
  - ACCESS (down-counter cnt, 4 bits).
  - RESP.
- Reset (rst_n low, asynchronous):
  - state = IDLE; cnt = 0.
  - All outputs 0.
  - Latched request registers = 0.
  - last_grant = LSU, so the IFU wins the first tie.
- IDLE, grant logic (combinational):
  - Only one valid: grant that requester.
  - Both valid: grant the requester that is not last_grant.
- IDLE, ready and acceptance:
  - x_req_ready = (state==IDLE) and grant==x. Ready is never high for both requesters; it is 0 in every other state.
  - Acceptance = valid && ready.
  - On the accepting edge: latch owner, addr, wen (IFU always 0), wdata, mask; last_grant = owner; cnt = LATENCY-1; go to ACCESS.
- ACCESS:
  - cnt != 0: decrement cnt; no strobe.
  - cnt == 0: assert exactly one strobe from the latched fields for exactly one cycle. A read asserts mem_ren with mem_raddr = addr. A write asserts mem_wen with waddr/wdata/mask.
  - In that same cycle, capture mem_rdata into the response register (reads only; writes capture 0), then go to RESP.
- RESP:
  - The owner's resp_valid is high for exactly one cycle; the other requester's resp_valid stays 0.
  - x_rdata holds the captured value from RESP until the next response to that requester.
  - Next state is IDLE.
  - There is no response back-pressure: requesters must sample on the pulse.
- Timing:
  - Request accepted at edge T → strobe during cycle T+LATENCY → resp_valid during cycle T+LATENCY+1.
  - Back-to-back throughput is one transaction per LATENCY+2 cycles.
- The request inputs are don't-care outside the accepting cycle. Changes after acceptance must not affect the strobe.
- The strobe count equals the acceptance count. A write is never issued twice; the memory port is combinational, so repeated strobes would repeat writes.
- Reset mid-ACCESS or mid-RESP: the transaction is dropped. No strobe and no response is issued afterwards, and last_grant returns to LSU.
- A request deasserted while not ready is simply not served; no grant state changes.

Test Plan:
- Reset, then IFU read only: ifu_req_valid=1, addr=0x80000000, mem returns 0x1122334455667788, LATENCY=1. Required: ready high in cycle 0; mem_ren and mem_raddr=0x80000000 for exactly one cycle at cycle 1; ifu_resp_valid at cycle 2 with ifu_rdata=0x1122334455667788; lsu_resp_valid stays 0.
- LSU store: wen=1, addr=0x80001000, wdata=0xDEADBEEF, mask=0x0F. Required: mem_wen exactly one cycle with those values; mem_ren=0; lsu_resp_valid pulse with lsu_rdata=0.
- Both requesters valid continuously from reset for 4 transactions. Required: grants alternate IFU, LSU, IFU, LSU; ready is never high for both in the same cycle.
- LATENCY=3, LSU load accepted at T. Required: no strobe at T+1 or T+2; mem_ren at T+3; lsu_resp_valid at T+4; ifu_req_ready=0 from T+1 through T+4.
- Change lsu_addr and lsu_wdata in the cycle after acceptance. Required: the strobe still carries the originally latched values.
- Assert rst_n=0 during ACCESS (LATENCY=3, cnt=1). Required: all outputs 0 immediately; no strobe or resp afterwards; with both requesters valid after release, the IFU is granted first.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Request/response and memory-port signals between IFU, LSU, the arbiter and the pmem wrapper.
// The slave modport is the arbiter's view; master is the surrounding core/memory view.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  logic                  ifu_req_valid;
  logic                  ifu_req_ready;
  logic [ADDR_W-1:0]     ifu_addr;
  logic                  ifu_resp_valid;
  logic [DATA_W-1:0]     ifu_rdata;

  logic                  lsu_req_valid;
  logic                  lsu_req_ready;
  logic                  lsu_wen;
  logic [ADDR_W-1:0]     lsu_addr;
  logic [DATA_W-1:0]     lsu_wdata;
  logic [DATA_W/8-1:0]   lsu_mask;
  logic                  lsu_resp_valid;
  logic [DATA_W-1:0]     lsu_rdata;

  logic                  mem_ren;
  logic                  mem_wen;
  logic [ADDR_W-1:0]     mem_raddr;
  logic [DATA_W-1:0]     mem_rdata;
  logic [ADDR_W-1:0]     mem_waddr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_mask;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata,
    input  lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_mask,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata,
    output mem_ren, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_mask,
    input  mem_rdata
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
    output lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_mask,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
    input  mem_ren, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_mask,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the single combinational pmem port between IFU and LSU: round-robin grant,
// one latched transaction at a time, one strobe after LATENCY cycles, one response pulse.
module mem_arbiter #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t                state;
  logic [3:0]            cnt;
  logic                  owner_lsu;
  logic                  last_lsu;
  logic                  r_wen;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W/8-1:0]   r_mask;
  logic [DATA_W-1:0]     ifu_rdata_q;
  logic [DATA_W-1:0]     lsu_rdata_q;

  logic                  grant_ifu;
  logic                  grant_lsu;
  logic                  accept;
  logic                  strobe;

  // On a tie the requester that did not win last time gets the port.
  assign grant_ifu = bus.ifu_req_valid && (!bus.lsu_req_valid || last_lsu);
  assign grant_lsu = bus.lsu_req_valid && (!bus.ifu_req_valid || !last_lsu);
  assign accept    = (state == IDLE) && (grant_ifu || grant_lsu);
  assign strobe    = (state == ACCESS) && (cnt == 4'd0);

  // Ready is gated by rst_n so every output reads 0 while reset is held.
  assign bus.ifu_req_ready  = rst_n && (state == IDLE) && grant_ifu;
  assign bus.lsu_req_ready  = rst_n && (state == IDLE) && grant_lsu;

  assign bus.mem_ren   = strobe && !r_wen;
  assign bus.mem_wen   = strobe && r_wen;
  assign bus.mem_raddr = bus.mem_ren ? r_addr  : '0;
  assign bus.mem_waddr = bus.mem_wen ? r_addr  : '0;
  assign bus.mem_wdata = bus.mem_wen ? r_wdata : '0;
  assign bus.mem_mask  = bus.mem_wen ? r_mask  : '0;

  assign bus.ifu_resp_valid = (state == RESP) && !owner_lsu;
  assign bus.lsu_resp_valid = (state == RESP) && owner_lsu;
  assign bus.ifu_rdata      = ifu_rdata_q;
  assign bus.lsu_rdata      = lsu_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      owner_lsu   <= 1'b0;
      last_lsu    <= 1'b1;
      r_wen       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_mask      <= '0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner_lsu <= grant_lsu;
            last_lsu  <= grant_lsu;
            r_wen     <= grant_lsu && bus.lsu_wen;
            r_addr    <= grant_lsu ? bus.lsu_addr  : bus.ifu_addr;
            r_wdata   <= grant_lsu ? bus.lsu_wdata : '0;
            r_mask    <= grant_lsu ? bus.lsu_mask  : '0;
            cnt       <= CNT_INIT;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            // Memory is combinational: capture read data in the strobe cycle itself.
            if (owner_lsu) lsu_rdata_q <= r_wen ? '0 : bus.mem_rdata;
            else           ifu_rdata_q <= bus.mem_rdata;
            state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (LATENCY 1 and 3) share one stimulus stream;
// directed scenarios plus random traffic checked against a transaction-age reference model.
module tb_mem_arbiter;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned OW = 6 + 5*64 + 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic          ifu_valid = 1'b0;
  logic [63:0]   ifu_addr  = '0;
  logic          lsu_valid = 1'b0;
  logic          lsu_wen   = 1'b0;
  logic [63:0]   lsu_addr  = '0;
  logic [63:0]   lsu_wdata = '0;
  logic [7:0]    lsu_mask  = '0;

  function automatic logic [63:0] memf(input logic [63:0] a);
    return a ^ 64'h1122_3344_D566_7788;
  endfunction

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

  mem_arbiter #(.LATENCY(1), .ADDR_W(AW), .DATA_W(DW)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  mem_arbiter #(.LATENCY(3), .ADDR_W(AW), .DATA_W(DW)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  assign bus1.ifu_req_valid = ifu_valid;  assign bus3.ifu_req_valid = ifu_valid;
  assign bus1.ifu_addr      = ifu_addr;   assign bus3.ifu_addr      = ifu_addr;
  assign bus1.lsu_req_valid = lsu_valid;  assign bus3.lsu_req_valid = lsu_valid;
  assign bus1.lsu_wen       = lsu_wen;    assign bus3.lsu_wen       = lsu_wen;
  assign bus1.lsu_addr      = lsu_addr;   assign bus3.lsu_addr      = lsu_addr;
  assign bus1.lsu_wdata     = lsu_wdata;  assign bus3.lsu_wdata     = lsu_wdata;
  assign bus1.lsu_mask      = lsu_mask;   assign bus3.lsu_mask      = lsu_mask;
  assign bus1.mem_rdata = bus1.mem_ren ? memf(bus1.mem_raddr) : '0;
  assign bus3.mem_rdata = bus3.mem_ren ? memf(bus3.mem_raddr) : '0;

  // Observed outputs, index 0 = LATENCY 1, index 1 = LATENCY 3.
  logic [1:0]  o_iready, o_lready, o_ren, o_wen, o_iresp, o_lresp;
  logic [63:0] o_raddr [2];
  logic [63:0] o_waddr [2];
  logic [63:0] o_wdata [2];
  logic [63:0] o_ird   [2];
  logic [63:0] o_lrd   [2];
  logic [7:0]  o_mask  [2];
  logic [OW-1:0] o_all [2];

  assign o_iready = {bus3.ifu_req_ready,  bus1.ifu_req_ready};
  assign o_lready = {bus3.lsu_req_ready,  bus1.lsu_req_ready};
  assign o_ren    = {bus3.mem_ren,        bus1.mem_ren};
  assign o_wen    = {bus3.mem_wen,        bus1.mem_wen};
  assign o_iresp  = {bus3.ifu_resp_valid, bus1.ifu_resp_valid};
  assign o_lresp  = {bus3.lsu_resp_valid, bus1.lsu_resp_valid};
  assign o_raddr[0] = bus1.mem_raddr;  assign o_raddr[1] = bus3.mem_raddr;
  assign o_waddr[0] = bus1.mem_waddr;  assign o_waddr[1] = bus3.mem_waddr;
  assign o_wdata[0] = bus1.mem_wdata;  assign o_wdata[1] = bus3.mem_wdata;
  assign o_mask[0]  = bus1.mem_mask;   assign o_mask[1]  = bus3.mem_mask;
  assign o_ird[0]   = bus1.ifu_rdata;  assign o_ird[1]   = bus3.ifu_rdata;
  assign o_lrd[0]   = bus1.lsu_rdata;  assign o_lrd[1]   = bus3.lsu_rdata;
  for (genvar g = 0; g < 2; g++) begin : g_all
    assign o_all[g] = {o_iready[g], o_lready[g], o_ren[g], o_wen[g], o_iresp[g], o_lresp[g],
                       o_raddr[g], o_waddr[g], o_wdata[g], o_ird[g], o_lrd[g], o_mask[g]};
  end

  // Reference model: m_k counts cycles since acceptance (0 = free); strobe at age L, response at age L+1.
  int          m_k    [2];
  bit          m_last [2];
  bit          m_own  [2];
  bit          m_wen  [2];
  logic [63:0] m_addr [2];
  logic [63:0] m_wdata[2];
  logic [7:0]  m_mask [2];
  logic [63:0] m_ird  [2];
  logic [63:0] m_lrd  [2];

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction
  function automatic bit e_ifu_rdy(input int i);
    return rst_n && (m_k[i] == 0) && ifu_valid && (!lsu_valid || m_last[i]);
  endfunction
  function automatic bit e_lsu_rdy(input int i);
    return rst_n && (m_k[i] == 0) && lsu_valid && (!ifu_valid || !m_last[i]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_k[i] <= 0; m_last[i] <= 1'b1; m_own[i] <= 1'b0; m_wen[i] <= 1'b0;
        m_addr[i] <= '0; m_wdata[i] <= '0; m_mask[i] <= '0; m_ird[i] <= '0; m_lrd[i] <= '0;
      end else if (m_k[i] == 0) begin
        if (e_ifu_rdy(i) || e_lsu_rdy(i)) begin
          m_own[i]   <= e_lsu_rdy(i);
          m_last[i]  <= e_lsu_rdy(i);
          m_wen[i]   <= e_lsu_rdy(i) && lsu_wen;
          m_addr[i]  <= e_lsu_rdy(i) ? lsu_addr : ifu_addr;
          m_wdata[i] <= lsu_wdata;
          m_mask[i]  <= lsu_mask;
          m_k[i]     <= 1;
        end
      end else if (m_k[i] == lat(i)) begin
        if (m_own[i]) m_lrd[i] <= m_wen[i] ? 64'd0 : memf(m_addr[i]);
        else          m_ird[i] <= memf(m_addr[i]);
        m_k[i] <= m_k[i] + 1;
      end else if (m_k[i] == lat(i) + 1) begin
        m_k[i] <= 0;
      end else begin
        m_k[i] <= m_k[i] + 1;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; ifu_valid = 1'b0; lsu_valid = 1'b0; lsu_wen = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    ifu_valid = 1'b0; lsu_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; ifu_valid = 1'b1; lsu_valid = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (o_all[i] !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs dut%0d: got %h want 0", i, o_all[i]);
      end
    end
    ifu_valid = 1'b0; lsu_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_ifu_read();
    @(negedge clk);
    ifu_valid = 1'b1; ifu_addr = 64'h8000_0000; lsu_valid = 1'b0;
    #1;
    n_checks++;
    if ({o_iready[0], o_lready[0]} !== 2'b10) begin
      n_fail++; $display("FAIL ifu_read_ready: got %b want 10", {o_iready[0], o_lready[0]});
    end
    @(negedge clk);
    ifu_valid = 1'b0; ifu_addr = 64'hFFFF_0000;
    #1;
    n_checks++;
    if ({o_ren[0], o_wen[0], o_raddr[0]} !== {2'b10, 64'h8000_0000}) begin
      n_fail++; $display("FAIL ifu_read_strobe: got ren=%b wen=%b raddr=%h want 1 0 80000000", o_ren[0], o_wen[0], o_raddr[0]);
    end
    @(negedge clk); #1;
    n_checks++;
    if ({o_iresp[0], o_lresp[0], o_ren[0], o_ird[0]} !== {3'b100, 64'h1122_3344_5566_7788}) begin
      n_fail++; $display("FAIL ifu_read_resp: got iresp=%b lresp=%b ren=%b rdata=%h want 1 0 0 1122334455667788",
                         o_iresp[0], o_lresp[0], o_ren[0], o_ird[0]);
    end
    @(negedge clk); #1;
    n_checks++;
    if ({o_iresp[0], o_ird[0]} !== {1'b0, 64'h1122_3344_5566_7788}) begin
      n_fail++; $display("FAIL ifu_read_hold: got iresp=%b rdata=%h want 0 1122334455667788", o_iresp[0], o_ird[0]);
    end
    idle_cycles(6);
  endtask

  task automatic test_store();
    @(negedge clk);
    lsu_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 64'h8000_1000; lsu_wdata = 64'hDEAD_BEEF; lsu_mask = 8'h0F;
    #1;
    n_checks++;
    if ({o_iready[0], o_lready[0]} !== 2'b01) begin
      n_fail++; $display("FAIL store_ready: got %b want 01", {o_iready[0], o_lready[0]});
    end
    @(negedge clk);
    lsu_valid = 1'b0; lsu_addr = 64'h1234_5678_9ABC_DEF0; lsu_wdata = 64'h5555_AAAA_5555_AAAA; lsu_mask = 8'hF0;
    #1;
    n_checks++;
    if ({o_ren[0], o_wen[0], o_waddr[0], o_wdata[0], o_mask[0]} !== {2'b01, 64'h8000_1000, 64'hDEAD_BEEF, 8'h0F}) begin
      n_fail++; $display("FAIL store_strobe_l1: got ren=%b wen=%b waddr=%h wdata=%h mask=%h want 0 1 80001000 deadbeef 0f",
                         o_ren[0], o_wen[0], o_waddr[0], o_wdata[0], o_mask[0]);
    end
    @(negedge clk); #1;
    n_checks++;
    if ({o_wen[0], o_lresp[0], o_iresp[0], o_lrd[0]} !== {3'b010, 64'd0}) begin
      n_fail++; $display("FAIL store_resp: got wen=%b lresp=%b iresp=%b lrdata=%h want 0 1 0 0",
                         o_wen[0], o_lresp[0], o_iresp[0], o_lrd[0]);
    end
    @(negedge clk); #1;
    n_checks++;
    if ({o_ren[1], o_wen[1], o_waddr[1], o_wdata[1], o_mask[1]} !== {2'b01, 64'h8000_1000, 64'hDEAD_BEEF, 8'h0F}) begin
      n_fail++; $display("FAIL store_strobe_l3: got ren=%b wen=%b waddr=%h wdata=%h mask=%h want 0 1 80001000 deadbeef 0f",
                         o_ren[1], o_wen[1], o_waddr[1], o_wdata[1], o_mask[1]);
    end
    idle_cycles(6);
  endtask

  task automatic test_latency3();
    @(negedge clk);
    lsu_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 64'h8000_3008; ifu_valid = 1'b0;
    #1;
    n_checks++;
    if (o_lready[1] !== 1'b1) begin
      n_fail++; $display("FAIL lat3_accept: got lsu_ready=%b want 1", o_lready[1]);
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      lsu_valid = 1'b0; lsu_addr = 64'hDEAD_0000_0000_0000 + 64'(k); ifu_valid = 1'b1;
      #1;
      n_checks++;
      if (o_iready[1] !== 1'b0) begin
        n_fail++; $display("FAIL lat3_ifu_ready T+%0d: got %b want 0", k, o_iready[1]);
      end
      n_checks++;
      if (k < 3 && {o_ren[1], o_wen[1]} !== 2'b00) begin
        n_fail++; $display("FAIL lat3_early_strobe T+%0d: got ren=%b wen=%b want 0 0", k, o_ren[1], o_wen[1]);
      end else if (k == 3 && {o_ren[1], o_raddr[1]} !== {1'b1, 64'h8000_3008}) begin
        n_fail++; $display("FAIL lat3_strobe T+3: got ren=%b raddr=%h want 1 80003008", o_ren[1], o_raddr[1]);
      end else if (k == 4 && {o_lresp[1], o_ren[1], o_lrd[1]} !== {2'b10, 64'h1122_3344_5566_4780}) begin
        n_fail++; $display("FAIL lat3_resp T+4: got lresp=%b ren=%b lrdata=%h want 1 0 1122334455664780",
                           o_lresp[1], o_ren[1], o_lrd[1]);
      end
    end
    idle_cycles(8);
  endtask

  task automatic test_fairness();
    int ng [2];
    bit both [2];
    do_reset();
    ng = '{0, 0}; both = '{0, 0};
    ifu_valid = 1'b1; lsu_valid = 1'b1; lsu_wen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      ifu_addr = 64'h8000_0000 + 64'(c * 4); lsu_addr = 64'h9000_0000 + 64'(c * 8);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (o_iready[i] && o_lready[i]) both[i] = 1'b1;
        if ((o_iready[i] || o_lready[i]) && ng[i] < 4) begin
          n_checks++;
          if (o_lready[i] !== ng[i][0]) begin
            n_fail++; $display("FAIL fair_grant dut%0d #%0d: got lsu=%b want %b", i, ng[i], o_lready[i], ng[i][0]);
          end
          ng[i]++;
        end
      end
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (ng[i] < 4 || both[i]) begin
        n_fail++; $display("FAIL fair_progress dut%0d: got grants=%0d both_ready=%b want >=4 0", i, ng[i], both[i]);
      end
    end
    idle_cycles(6);
  endtask

  task automatic test_reset_mid_access();
    bit seen;
    do_reset();
    lsu_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 64'h8000_2000; ifu_valid = 1'b0;
    #1;
    n_checks++;
    if (o_lready[1] !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_accept: got %b want 1", o_lready[1]);
    end
    @(negedge clk);
    lsu_valid = 1'b0;
    @(negedge clk);
    ifu_valid = 1'b1; lsu_valid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (o_all[i] !== '0) begin
        n_fail++; $display("FAIL rstmid_outputs dut%0d: got %h want 0", i, o_all[i]);
      end
    end
    @(negedge clk);
    ifu_valid = 1'b0; lsu_valid = 1'b0;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (o_ren[1] || o_wen[1] || o_iresp[1] || o_lresp[1]) seen = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (seen) begin
      n_fail++; $display("FAIL rstmid_dropped: got strobe_or_resp=1 want 0");
    end
    ifu_valid = 1'b1; lsu_valid = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({o_iready[i], o_lready[i]} !== 2'b10) begin
        n_fail++; $display("FAIL rstmid_first_grant dut%0d: got %b want 10", i, {o_iready[i], o_lready[i]});
      end
    end
    idle_cycles(6);
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      ifu_valid = 1'($urandom_range(0, 1));
      lsu_valid = 1'($urandom_range(0, 1));
      lsu_wen   = 1'($urandom_range(0, 1));
      ifu_addr  = {$urandom, $urandom};
      lsu_addr  = {$urandom, $urandom};
      lsu_wdata = {$urandom, $urandom};
      lsu_mask  = 8'($urandom);
      #1;
      for (int i = 0; i < 2; i++) begin
        logic          e_str;
        logic [1:0]    e_rdy;
        logic [201:0]  e_mem;
        logic [129:0]  e_rsp;
        e_str = (m_k[i] == lat(i));
        e_rdy = {e_ifu_rdy(i), e_lsu_rdy(i)};
        e_mem = {e_str && !m_wen[i], e_str && m_wen[i],
                 (e_str && !m_wen[i]) ? m_addr[i] : 64'd0,
                 (e_str && m_wen[i]) ? m_addr[i] : 64'd0,
                 (e_str && m_wen[i]) ? m_wdata[i] : 64'd0,
                 (e_str && m_wen[i]) ? m_mask[i] : 8'd0};
        e_rsp = {(m_k[i] == lat(i) + 1) && !m_own[i], (m_k[i] == lat(i) + 1) && m_own[i], m_ird[i], m_lrd[i]};
        n_checks++;
        if ({o_iready[i], o_lready[i]} !== e_rdy) begin
          n_fail++; $display("FAIL rand_ready dut%0d cyc%0d: got %b want %b", i, c, {o_iready[i], o_lready[i]}, e_rdy);
        end
        n_checks++;
        if ({o_ren[i], o_wen[i], o_raddr[i], o_waddr[i], o_wdata[i], o_mask[i]} !== e_mem) begin
          n_fail++; $display("FAIL rand_mem dut%0d cyc%0d: got %h want %h", i, c,
                             {o_ren[i], o_wen[i], o_raddr[i], o_waddr[i], o_wdata[i], o_mask[i]}, e_mem);
        end
        n_checks++;
        if ({o_iresp[i], o_lresp[i], o_ird[i], o_lrd[i]} !== e_rsp) begin
          n_fail++; $display("FAIL rand_resp dut%0d cyc%0d: got %h want %h", i, c,
                             {o_iresp[i], o_lresp[i], o_ird[i], o_lrd[i]}, e_rsp);
        end
      end
      @(negedge clk);
    end
    idle_cycles(6);
  endtask

  initial begin
    test_reset();
    test_ifu_read();
    test_store();
    test_latency3();
    test_fairness();
    test_reset_mid_access();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
